// File: rtl/kb_code_checker.sv
// kb_code_checker
//   Keypad entry stage ahead of the alarm main controller. Synchronises the
//   raw keypad digit/strobe, assembles 4-digit entries, compares each entry
//   against CODE and reports the result as a single-cycle pulse. Discards a
//   partial entry after an inter-digit timeout, and locks the keypad out for
//   LOCK_CYCLES after MAX_FAIL consecutive wrong entries.
//
// Ports
//   CLK         system clock, all logic on the rising edge
//   RESET       synchronous, active-high reset
//   KB_IN[1:0]  keypad digit (asynchronous to CLK)
//   KB_RECV     keypad digit strobe (asynchronous, active-high)
//   CODE_OK     one-cycle pulse: completed entry matched CODE
//   CODE_BAD    one-cycle pulse: completed entry did not match CODE
//   ENTRY_BUSY  high while 1 to 3 digits of an entry are held
//   DIGIT_CNT   number of digits held in the current entry (0..3)
//   LOCKED_OUT  high during lockout
module kb_code_checker #(
  parameter logic [7:0]  CODE           = 8'b00_01_10_11,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCK_CYCLES    = 10000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] KB_IN,
  input  logic       KB_RECV,
  output logic       CODE_OK,
  output logic       CODE_BAD,
  output logic       ENTRY_BUSY,
  output logic [1:0] DIGIT_CNT,
  output logic       LOCKED_OUT
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [TW-1:0] TMR_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCK_CYCLES - 1);
  localparam logic [3:0]    FAIL_LIMIT = 4'(MAX_FAIL);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    CHECK,
    LOCKED
  } state_e;

  // Input synchronisers and edge detector
  logic       recv_s1_q, recv_s2_q, recv_prev_q;
  logic [1:0] kb_s1_q, kb_s2_q;
  logic       accept;

  state_e        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [3:0]    fail_q, fail_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          code_ok, code_bad;

  // The edge detector runs in every state so a strobe held across lockout
  // does not produce an accept when the lock ends.
  assign accept = recv_s2_q & ~recv_prev_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    tmr_d    = tmr_q;
    lock_d   = lock_q;
    code_ok  = 1'b0;
    code_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = {shreg_q[5:0], kb_s2_q};
          cnt_d   = 2'd1;
          tmr_d   = '0;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        // An accept in the expiry cycle wins over the timeout.
        if (accept) begin
          shreg_d = {shreg_q[5:0], kb_s2_q};
          tmr_d   = '0;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmr_q == TMR_LAST) begin
          cnt_d   = 2'd0;
          tmr_d   = '0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (shreg_q == CODE) begin
          code_ok = 1'b1;
          fail_d  = '0;
        end else begin
          code_bad = 1'b1;
          if (fail_q + 4'd1 == FAIL_LIMIT) begin
            fail_d  = '0;
            lock_d  = LOCK_LOAD;
            state_d = LOCKED;
          end else begin
            fail_d = fail_q + 4'd1;
          end
        end
      end
      LOCKED: begin
        if (lock_q == '0) begin
          state_d = IDLE;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      recv_s1_q   <= 1'b0;
      recv_s2_q   <= 1'b0;
      recv_prev_q <= 1'b0;
      kb_s1_q     <= '0;
      kb_s2_q     <= '0;
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      fail_q      <= '0;
      tmr_q       <= '0;
      lock_q      <= '0;
    end else begin
      recv_s1_q   <= KB_RECV;
      recv_s2_q   <= recv_s1_q;
      recv_prev_q <= recv_s2_q;
      kb_s1_q     <= KB_IN;
      kb_s2_q     <= kb_s1_q;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      fail_q      <= fail_d;
      tmr_q       <= tmr_d;
      lock_q      <= lock_d;
    end
  end

  assign CODE_OK    = code_ok;
  assign CODE_BAD   = code_bad;
  assign ENTRY_BUSY = (state_q == ENTRY);
  assign DIGIT_CNT  = cnt_q;
  assign LOCKED_OUT = (state_q == LOCKED);

endmodule

// File: tb/tb_kb_code_checker.sv
// tb_kb_code_checker
//   Scoreboard bench for kb_code_checker. Stimulus tasks feed keypad strobes
//   and update a behavioural model (held digits, accept times, fail count,
//   lock window); the model pushes expected result pulses into a queue and
//   writes per-cycle expected DIGIT_CNT/LOCKED_OUT levels. A monitor on the
//   falling edge compares the DUT against those expectations.
module tb_kb_code_checker;

  localparam int T    = 20;
  localparam int L    = 50;
  localparam int MF   = 3;
  localparam logic [7:0] CODE = 8'b00_01_10_11;
  localparam int MAXC = 6000;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       KB_RECV;
  logic [1:0] KB_IN;
  logic       CODE_OK, CODE_BAD, ENTRY_BUSY, LOCKED_OUT;
  logic [1:0] DIGIT_CNT;

  kb_code_checker #(
    .CODE          (CODE),
    .TIMEOUT_CYCLES(T),
    .MAX_FAIL      (MF),
    .LOCK_CYCLES   (L)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .KB_IN     (KB_IN),
    .KB_RECV   (KB_RECV),
    .CODE_OK   (CODE_OK),
    .CODE_BAD  (CODE_BAD),
    .ENTRY_BUSY(ENTRY_BUSY),
    .DIGIT_CNT (DIGIT_CNT),
    .LOCKED_OUT(LOCKED_OUT)
  );

  always #5 CLK = ~CLK;

  // cyc == number of rising edges seen; sampled on the falling edge it
  // describes the state left by rising edge 'cyc'.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model state
  int         held[$];
  int         last_acc = 0;
  int         fails    = 0;
  int         lock_lo  = 0;
  int         lock_hi  = -1;
  int         sb_at[$];
  bit         sb_ok[$];
  logic [1:0] exp_cnt [MAXC];
  bit         exp_lock[MAXC];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit done   = 1'b0;

  function automatic int code_digit(input int idx);
    int c;
    c = int'(CODE);
    return (c >> (6 - 2 * idx)) & 3;
  endfunction

  task automatic fill_cnt(input int x, input int k);
    for (int i = x; i < x + T && i < MAXC; i++) exp_cnt[i] = 2'(k);
  endtask

  // Digit d takes effect at rising edge x.
  task automatic model_accept(input int d, input int x);
    int code;
    if (x >= lock_lo && x <= lock_hi) return;
    if (held.size() > 0 && x - last_acc > T) held.delete();
    held.push_back(d);
    last_acc = x;
    if (held.size() == 4) begin
      code = held[0] * 64 + held[1] * 16 + held[2] * 4 + held[3];
      held.delete();
      fill_cnt(x, 0);
      sb_at.push_back(x);
      sb_ok.push_back(code == int'(CODE));
      if (code == int'(CODE)) begin
        fails = 0;
      end else begin
        fails++;
        if (fails == MF) begin
          fails   = 0;
          lock_lo = x + 2;
          lock_hi = x + L + 1;
          for (int i = x + 1; i <= x + L && i < MAXC; i++) exp_lock[i] = 1'b1;
        end
      end
    end else begin
      fill_cnt(x, held.size());
    end
  endtask

  task automatic model_reset(input int r);
    held.delete();
    fails   = 0;
    lock_lo = 0;
    lock_hi = -1;
    for (int i = r; i <= r + L + T + 2 && i < MAXC; i++) begin
      exp_cnt[i]  = 2'd0;
      exp_lock[i] = 1'b0;
    end
    while (sb_at.size() > 0 && sb_at[sb_at.size()-1] >= r) begin
      void'(sb_at.pop_back());
      void'(sb_ok.pop_back());
    end
  endtask

  // Called just after a falling edge. Raises the strobe now, drops it after
  // 'hold' cycles, optionally flips KB_IN after 'chg' cycles, and returns on
  // the falling edge 'spacing' cycles after the rise.
  task automatic send_digit(input int d, input int hold, input int spacing, input int chg);
    KB_IN   = d[1:0];
    KB_RECV = 1'b1;
    model_accept(d, cyc + 3);
    for (int i = 1; i < spacing; i++) begin
      @(negedge CLK);
      if (i == hold) KB_RECV = 1'b0;
      if (chg > 0 && i == chg) KB_IN = ~KB_IN;
    end
    @(negedge CLK);
  endtask

  task automatic send_entry(input int d0, input int d1, input int d2, input int d3);
    send_digit(d0, 2, 5, 0);
    send_digit(d1, 2, 5, 0);
    send_digit(d2, 2, 5, 0);
    send_digit(d3, 2, 5, 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    model_reset(cyc + 1);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor / scoreboard
  int mon_at;
  bit mon_ok;
  always @(negedge CLK) begin
    if (chk_en && !done && cyc < MAXC) begin
      checks++;
      if (DIGIT_CNT !== exp_cnt[cyc]) begin
        errors++;
        $display("FAIL digit_cnt cyc=%0d got=%0d exp=%0d", cyc, DIGIT_CNT, exp_cnt[cyc]);
      end
      checks++;
      if (ENTRY_BUSY !== (exp_cnt[cyc] != 2'd0)) begin
        errors++;
        $display("FAIL entry_busy cyc=%0d got=%b exp=%b", cyc, ENTRY_BUSY, exp_cnt[cyc] != 2'd0);
      end
      checks++;
      if (LOCKED_OUT !== exp_lock[cyc]) begin
        errors++;
        $display("FAIL locked_out cyc=%0d got=%b exp=%b", cyc, LOCKED_OUT, exp_lock[cyc]);
      end
      checks++;
      if (CODE_OK === 1'b1 || CODE_BAD === 1'b1) begin
        if (sb_at.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d ok=%b bad=%b exp=none", cyc, CODE_OK, CODE_BAD);
        end else begin
          mon_at = sb_at.pop_front();
          mon_ok = sb_ok.pop_front();
          if (mon_at != cyc || CODE_OK !== mon_ok || CODE_BAD !== !mon_ok) begin
            errors++;
            $display("FAIL result_pulse cyc=%0d ok=%b bad=%b exp_cyc=%0d exp_ok=%b",
                     cyc, CODE_OK, CODE_BAD, mon_at, mon_ok);
          end
        end
      end else if (CODE_OK !== 1'b0 || CODE_BAD !== 1'b0) begin
        errors++;
        $display("FAIL result_level cyc=%0d ok=%b bad=%b exp=00", cyc, CODE_OK, CODE_BAD);
      end else if (sb_at.size() > 0 && sb_at[0] <= cyc) begin
        errors++;
        $display("FAIL missing_pulse cyc=%0d got=none exp_cyc=%0d exp_ok=%b", cyc, sb_at[0], sb_ok[0]);
        void'(sb_at.pop_front());
        void'(sb_ok.pop_front());
      end
    end
    if (done || cyc >= MAXC - 1) begin
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 1);
      end else if (sb_at.size() != 0) begin
        errors++;
        $display("FAIL drain pending=%0d exp=0", sb_at.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    int d, hold, sp, chg;
    for (int i = 0; i < MAXC; i++) begin
      exp_cnt[i]  = 2'd0;
      exp_lock[i] = 1'b0;
    end
    RESET   = 1'b1;
    KB_RECV = 1'b0;
    KB_IN   = 2'd0;
    idle(3);
    RESET  = 1'b0;
    chk_en = 1'b1;
    idle(4);

    // Correct entry, then wrong entry, then correct clears the fail count
    send_entry(0, 1, 2, 3);
    send_entry(3, 3, 3, 3);
    send_entry(0, 1, 2, 3);
    send_entry(3, 3, 3, 3);
    send_entry(2, 2, 2, 2);
    send_entry(0, 1, 2, 3);

    // Lockout, entry attempted while locked, then recovery
    send_entry(3, 3, 3, 3);
    send_entry(1, 1, 1, 1);
    send_entry(3, 2, 1, 0);
    send_entry(0, 1, 2, 3);
    idle(40);
    send_entry(0, 1, 2, 3);

    // Timeout discards old digits; 19 and 20 cycle gaps keep the entry
    send_digit(0, 2, 5, 0);
    send_digit(1, 2, 25, 0);
    send_entry(2, 3, 0, 1);
    send_digit(0, 2, 5, 0);
    send_digit(1, 2, 19, 0);
    send_digit(2, 2, 5, 0);
    send_digit(3, 2, 5, 0);
    send_digit(0, 2, 20, 0);
    send_digit(1, 2, 5, 0);
    send_digit(2, 2, 5, 0);
    send_digit(3, 2, 5, 0);

    // Held strobe gives one accept; late KB_IN change is not captured
    send_digit(0, 10, 13, 0);
    send_digit(1, 2, 5, 0);
    send_digit(2, 2, 5, 0);
    send_digit(3, 2, 5, 0);
    send_digit(0, 2, 5, 3);
    send_digit(1, 2, 5, 0);
    send_digit(2, 2, 5, 3);
    send_digit(3, 2, 5, 0);

    // Reset mid-entry
    send_digit(0, 2, 5, 0);
    send_digit(1, 2, 5, 0);
    send_digit(2, 2, 5, 0);
    do_reset();
    idle(2);
    send_digit(3, 2, 5, 0);
    idle(T + 5);

    // Randomised traffic
    while (cyc < MAXC - 400) begin
      if ($urandom_range(0, 1) == 0) d = code_digit(held.size() % 4);
      else d = int'($urandom_range(0, 3));
      hold = int'($urandom_range(2, 6));
      sp   = hold + int'($urandom_range(3, 8));
      if ($urandom_range(0, 11) == 0) sp = int'($urandom_range(15, 26));
      chg  = ($urandom_range(0, 5) == 0) ? 3 : 0;
      send_digit(d, hold, sp, chg);
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    idle(L + T + 10);
    done = 1'b1;
  end

endmodule
